// File: rtl/axilite_slave_pkg.sv
// Shared types and constants for the AXI4-Lite responder and its helpers.
package axilite_slave_pkg;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_REQ,
        WR_WAIT,
        WR_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_REQ,
        RD_WAIT,
        RD_RESP
    } rd_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int TIMEOUT_W = 16;

endpackage

// File: rtl/axilite_slave_timeout.sv
// Backend wait timer: cleared before a wait, counts while enabled, and flags
// expiry in the cycle where the count would reach TIMEOUT_CYCLES.
module axilite_slave_timeout
    import axilite_slave_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic axi_aclk,
    input  logic axi_aresetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Expiry fires while the count equals TIMEOUT_CYCLES-1 so the owning FSM
    // leaves its wait state exactly TIMEOUT_CYCLES cycles after entering it.
    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] cnt;

    // Saturating wait counter
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != '1)) begin
            cnt <= cnt + TIMEOUT_W'(1);
        end
    end

    // Expiry decode; a zero limit disables the timeout entirely
    always_comb begin
        expired = 1'b0;
        if ((TIMEOUT_CYCLES != 0) && enable && (cnt >= LIMIT)) begin
            expired = 1'b1;
        end
    end

endmodule

// File: rtl/axilite_slave.sv
// AXI4-Lite responder: turns write/read transactions into one-cycle backend
// request pulses, waits for backend completion (with optional timeout) and
// returns the AXI response. Write and read paths run independently.
module axilite_slave
    import axilite_slave_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        axi_aclk,
    input  logic        axi_aresetn,
    input  logic        axi_awvalid,
    input  logic [31:0] axi_awaddr,
    output logic        axi_awready,
    input  logic        axi_wvalid,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    output logic        axi_wready,
    output logic        axi_bvalid,
    output logic [1:0]  axi_bresp,
    input  logic        axi_bready,
    input  logic        axi_arvalid,
    input  logic [31:0] axi_araddr,
    output logic        axi_arready,
    output logic        axi_rvalid,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    input  logic        axi_rready,
    output logic        bk_wstart,
    output logic [31:0] bk_waddr,
    output logic [31:0] bk_wdata,
    output logic [3:0]  bk_wstrb,
    input  logic        bk_wdone,
    output logic        bk_rstart,
    output logic [31:0] bk_raddr,
    input  logic [31:0] bk_rdata,
    input  logic        bk_rdone
);

    // ---------------- write path state ----------------
    wr_state_t   wr_state, wr_next;
    logic        aw_got_q, aw_got_n;
    logic        w_got_q, w_got_n;
    logic        awready_q, awready_n;
    logic        wready_q, wready_n;
    logic        bvalid_q, bvalid_n;
    logic [1:0]  bresp_q, bresp_n;
    logic        wstart_q, wstart_n;
    logic [31:0] waddr_q, waddr_n;
    logic [31:0] wdata_q, wdata_n;
    logic [3:0]  wstrb_q, wstrb_n;
    logic        wr_to_expired;

    // ---------------- read path state ----------------
    rd_state_t   rd_state, rd_next;
    logic        arready_q, arready_n;
    logic        rvalid_q, rvalid_n;
    logic [31:0] rdata_q, rdata_n;
    logic [1:0]  rresp_q, rresp_n;
    logic        rstart_q, rstart_n;
    logic [31:0] raddr_q, raddr_n;
    logic        rd_to_expired;

    axilite_slave_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wr_timeout (
        .axi_aclk   (axi_aclk),
        .axi_aresetn(axi_aresetn),
        .clear      (wr_state == WR_REQ),
        .enable     (wr_state == WR_WAIT),
        .expired    (wr_to_expired)
    );

    axilite_slave_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rd_timeout (
        .axi_aclk   (axi_aclk),
        .axi_aresetn(axi_aresetn),
        .clear      (rd_state == RD_REQ),
        .enable     (rd_state == RD_WAIT),
        .expired    (rd_to_expired)
    );

    // Write FSM next-state and registered-output next values
    always_comb begin
        wr_next   = wr_state;
        aw_got_n  = aw_got_q;
        w_got_n   = w_got_q;
        awready_n = awready_q;
        wready_n  = wready_q;
        bvalid_n  = bvalid_q;
        bresp_n   = bresp_q;
        wstart_n  = 1'b0;
        waddr_n   = waddr_q;
        wdata_n   = wdata_q;
        wstrb_n   = wstrb_q;
        unique case (wr_state)
            WR_IDLE: begin
                if (axi_awvalid && awready_q) begin
                    waddr_n  = axi_awaddr;
                    aw_got_n = 1'b1;
                end
                if (axi_wvalid && wready_q) begin
                    wdata_n = axi_wdata;
                    wstrb_n = axi_wstrb;
                    w_got_n = 1'b1;
                end
                // Readies are derived from the captured flags so they come up
                // on the first edge after reset and drop at their own handshake.
                awready_n = ~aw_got_n;
                wready_n  = ~w_got_n;
                if (aw_got_n && w_got_n) begin
                    aw_got_n = 1'b0;
                    w_got_n  = 1'b0;
                    wstart_n = 1'b1;
                    wr_next  = WR_REQ;
                end
            end
            WR_REQ: begin
                wr_next = WR_WAIT;
            end
            WR_WAIT: begin
                if (bk_wdone) begin
                    bvalid_n = 1'b1;
                    bresp_n  = RESP_OKAY;
                    wr_next  = WR_RESP;
                end else if (wr_to_expired) begin
                    bvalid_n = 1'b1;
                    bresp_n  = RESP_SLVERR;
                    wr_next  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axi_bready) begin
                    bvalid_n  = 1'b0;
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                    wr_next   = WR_IDLE;
                end
            end
        endcase
    end

    // Write FSM state and output registers
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wr_state  <= WR_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            wstart_q  <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            wr_state  <= wr_next;
            aw_got_q  <= aw_got_n;
            w_got_q   <= w_got_n;
            awready_q <= awready_n;
            wready_q  <= wready_n;
            bvalid_q  <= bvalid_n;
            bresp_q   <= bresp_n;
            wstart_q  <= wstart_n;
            waddr_q   <= waddr_n;
            wdata_q   <= wdata_n;
            wstrb_q   <= wstrb_n;
        end
    end

    // Read FSM next-state and registered-output next values
    always_comb begin
        rd_next   = rd_state;
        arready_n = arready_q;
        rvalid_n  = rvalid_q;
        rdata_n   = rdata_q;
        rresp_n   = rresp_q;
        rstart_n  = 1'b0;
        raddr_n   = raddr_q;
        unique case (rd_state)
            RD_IDLE: begin
                arready_n = 1'b1;
                if (axi_arvalid && arready_q) begin
                    raddr_n   = axi_araddr;
                    arready_n = 1'b0;
                    rstart_n  = 1'b1;
                    rd_next   = RD_REQ;
                end
            end
            RD_REQ: begin
                rd_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (bk_rdone) begin
                    rvalid_n = 1'b1;
                    rdata_n  = bk_rdata;
                    rresp_n  = RESP_OKAY;
                    rd_next  = RD_RESP;
                end else if (rd_to_expired) begin
                    rvalid_n = 1'b1;
                    rdata_n  = '0;
                    rresp_n  = RESP_SLVERR;
                    rd_next  = RD_RESP;
                end
            end
            RD_RESP: begin
                if (axi_rready) begin
                    rvalid_n  = 1'b0;
                    arready_n = 1'b1;
                    rd_next   = RD_IDLE;
                end
            end
        endcase
    end

    // Read FSM state and output registers
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rd_state  <= RD_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rstart_q  <= 1'b0;
            raddr_q   <= '0;
        end else begin
            rd_state  <= rd_next;
            arready_q <= arready_n;
            rvalid_q  <= rvalid_n;
            rdata_q   <= rdata_n;
            rresp_q   <= rresp_n;
            rstart_q  <= rstart_n;
            raddr_q   <= raddr_n;
        end
    end

    assign axi_awready = awready_q;
    assign axi_wready  = wready_q;
    assign axi_bvalid  = bvalid_q;
    assign axi_bresp   = bresp_q;
    assign bk_wstart   = wstart_q;
    assign bk_waddr    = waddr_q;
    assign bk_wdata    = wdata_q;
    assign bk_wstrb    = wstrb_q;
    assign axi_arready = arready_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;
    assign bk_rstart   = rstart_q;
    assign bk_raddr    = raddr_q;

endmodule

// File: tb/tb_axilite_slave.sv
// Directed bench for axilite_slave: a vector table of single transactions
// plus hand-written sequences for ordering, concurrency and reset corners.
module tb_axilite_slave;

    localparam int TO = 8;

    logic        axi_aclk;
    logic        axi_aresetn;
    logic        axi_awvalid;
    logic [31:0] axi_awaddr;
    logic        axi_awready;
    logic        axi_wvalid;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wready;
    logic        axi_bvalid;
    logic [1:0]  axi_bresp;
    logic        axi_bready;
    logic        axi_arvalid;
    logic [31:0] axi_araddr;
    logic        axi_arready;
    logic        axi_rvalid;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rready;
    logic        bk_wstart;
    logic [31:0] bk_waddr;
    logic [31:0] bk_wdata;
    logic [3:0]  bk_wstrb;
    logic        bk_wdone;
    logic        bk_rstart;
    logic [31:0] bk_raddr;
    logic [31:0] bk_rdata;
    logic        bk_rdone;

    int compared   = 0;
    int mismatched = 0;

    axilite_slave #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .axi_aclk   (axi_aclk),
        .axi_aresetn(axi_aresetn),
        .axi_awvalid(axi_awvalid),
        .axi_awaddr (axi_awaddr),
        .axi_awready(axi_awready),
        .axi_wvalid (axi_wvalid),
        .axi_wdata  (axi_wdata),
        .axi_wstrb  (axi_wstrb),
        .axi_wready (axi_wready),
        .axi_bvalid (axi_bvalid),
        .axi_bresp  (axi_bresp),
        .axi_bready (axi_bready),
        .axi_arvalid(axi_arvalid),
        .axi_araddr (axi_araddr),
        .axi_arready(axi_arready),
        .axi_rvalid (axi_rvalid),
        .axi_rdata  (axi_rdata),
        .axi_rresp  (axi_rresp),
        .axi_rready (axi_rready),
        .bk_wstart  (bk_wstart),
        .bk_waddr   (bk_waddr),
        .bk_wdata   (bk_wdata),
        .bk_wstrb   (bk_wstrb),
        .bk_wdone   (bk_wdone),
        .bk_rstart  (bk_rstart),
        .bk_raddr   (bk_raddr),
        .bk_rdata   (bk_rdata),
        .bk_rdone   (bk_rdone)
    );

    initial begin
        axi_aclk = 1'b0;
        forever #5 axi_aclk = ~axi_aclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;      // write data, or backend read data
        logic [3:0]  strb;
        int          done_dly;  // cycles from start pulse to done; -1 = silent
        int          hold;      // cycles of bready/rready low after response
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic do_write(input vec_t v);
        int n;
        axi_awaddr  = v.addr;
        axi_wdata   = v.data;
        axi_wstrb   = v.strb;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        n = 0;
        while (!(axi_awready && axi_wready) && n < 10) begin
            tick();
            n++;
        end
        chk("wr_ready_wait", 32'(n < 10), 32'd1);
        tick();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        chk("wr_start", 32'(bk_wstart), 32'd1);
        chk("wr_addr", bk_waddr, v.addr);
        chk("wr_data", bk_wdata, v.data);
        chk("wr_strb", 32'(bk_wstrb), 32'(v.strb));
        chk("wr_awready_low", 32'(axi_awready), 32'd0);
        tick();
        chk("wr_start_pulse", 32'(bk_wstart), 32'd0);
        if (v.done_dly >= 1) begin
            repeat (v.done_dly - 1) tick();
            bk_wdone = 1'b1;
            tick();
            bk_wdone = 1'b0;
        end else begin
            n = 1;
            while (!axi_bvalid && n < 40) begin
                tick();
                n++;
            end
            chk("wr_timeout_cycles", 32'(n), 32'(TO + 1));
        end
        chk("wr_bvalid", 32'(axi_bvalid), 32'd1);
        chk("wr_bresp", 32'(axi_bresp), 32'(v.exp_resp));
        if (v.done_dly < 1) begin
            bk_wdone = 1'b1;
            tick();
            bk_wdone = 1'b0;
            chk("wr_late_done_bresp", 32'(axi_bresp), 32'(v.exp_resp));
        end
        repeat (v.hold) begin
            tick();
            chk("wr_bvalid_held", 32'(axi_bvalid), 32'd1);
        end
        axi_bready = 1'b1;
        tick();
        axi_bready = 1'b0;
        chk("wr_bvalid_drop", 32'(axi_bvalid), 32'd0);
        chk("wr_awready_back", 32'(axi_awready), 32'd1);
        chk("wr_wready_back", 32'(axi_wready), 32'd1);
        if (v.done_dly < 1) begin
            bk_wdone = 1'b1;
            tick();
            bk_wdone = 1'b0;
            repeat (3) begin
                tick();
                chk("wr_no_second_resp", 32'(axi_bvalid), 32'd0);
            end
        end
    endtask

    task automatic do_read(input vec_t v);
        int n;
        axi_araddr  = v.addr;
        axi_arvalid = 1'b1;
        n = 0;
        while (!axi_arready && n < 10) begin
            tick();
            n++;
        end
        chk("rd_ready_wait", 32'(n < 10), 32'd1);
        tick();
        axi_arvalid = 1'b0;
        chk("rd_start", 32'(bk_rstart), 32'd1);
        chk("rd_addr", bk_raddr, v.addr);
        chk("rd_arready_low", 32'(axi_arready), 32'd0);
        tick();
        chk("rd_start_pulse", 32'(bk_rstart), 32'd0);
        if (v.done_dly >= 1) begin
            repeat (v.done_dly - 1) tick();
            bk_rdone = 1'b1;
            bk_rdata = v.data;
            tick();
            bk_rdone = 1'b0;
            bk_rdata = 32'h0BAD_0BAD;
        end else begin
            bk_rdata = 32'h0BAD_0BAD;
            n = 1;
            while (!axi_rvalid && n < 40) begin
                tick();
                n++;
            end
            chk("rd_timeout_cycles", 32'(n), 32'(TO + 1));
        end
        chk("rd_rvalid", 32'(axi_rvalid), 32'd1);
        chk("rd_rresp", 32'(axi_rresp), 32'(v.exp_resp));
        chk("rd_rdata", axi_rdata, v.exp_rdata);
        repeat (v.hold) begin
            tick();
            chk("rd_rvalid_held", 32'(axi_rvalid), 32'd1);
            chk("rd_rdata_held", axi_rdata, v.exp_rdata);
            chk("rd_arready_held_low", 32'(axi_arready), 32'd0);
        end
        axi_rready = 1'b1;
        tick();
        axi_rready = 1'b0;
        chk("rd_rvalid_drop", 32'(axi_rvalid), 32'd0);
        chk("rd_arready_back", 32'(axi_arready), 32'd1);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 32'h0000_1000, 32'hA5A5_0001, 4'hF, 2,  0, 2'b00, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_3008, 32'hDEAD_BEEF, 4'h0, 1,  4, 2'b00, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h0000_0044, 32'h1234_5678, 4'h6, 1,  2, 2'b00, 32'h0};
        vecs[3] = '{1'b1, 32'h0000_00F0, 32'h0000_0099, 4'h3, -1, 0, 2'b10, 32'h0};
        vecs[4] = '{1'b0, 32'h0000_0F00, 32'h0000_0000, 4'h0, -1, 1, 2'b10, 32'h0};
        vecs[5] = '{1'b0, 32'h0000_0000, 32'h0000_0001, 4'h0, 5,  0, 2'b00, 32'h0000_0001};

        axi_aresetn = 1'b0;
        axi_awvalid = 1'b0; axi_awaddr = '0;
        axi_wvalid  = 1'b0; axi_wdata  = '0; axi_wstrb = '0;
        axi_bready  = 1'b0;
        axi_arvalid = 1'b0; axi_araddr = '0;
        axi_rready  = 1'b0;
        bk_wdone    = 1'b0; bk_rdone = 1'b0; bk_rdata = '0;

        // Reset state, then readies rise on the first edge after release
        #12;
        chk("rst_awready", 32'(axi_awready), 32'd0);
        chk("rst_arready", 32'(axi_arready), 32'd0);
        chk("rst_bvalid", 32'(axi_bvalid), 32'd0);
        chk("rst_rvalid", 32'(axi_rvalid), 32'd0);
        axi_aresetn = 1'b1;
        tick();
        chk("rel_awready", 32'(axi_awready), 32'd1);
        chk("rel_wready", 32'(axi_wready), 32'd1);
        chk("rel_arready", 32'(axi_arready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i]);
            else               do_read(vecs[i]);
        end

        // W three cycles ahead of AW
        axi_wdata  = 32'h0000_0055;
        axi_wstrb  = 4'h1;
        axi_wvalid = 1'b1;
        tick();
        axi_wvalid = 1'b0;
        chk("wfirst_wready_low", 32'(axi_wready), 32'd0);
        chk("wfirst_awready_high", 32'(axi_awready), 32'd1);
        chk("wfirst_no_start", 32'(bk_wstart), 32'd0);
        repeat (2) begin
            tick();
            chk("wfirst_no_start_wait", 32'(bk_wstart), 32'd0);
        end
        axi_awaddr  = 32'h0000_2004;
        axi_awvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        chk("wfirst_start", 32'(bk_wstart), 32'd1);
        chk("wfirst_addr", bk_waddr, 32'h0000_2004);
        chk("wfirst_data", bk_wdata, 32'h0000_0055);
        chk("wfirst_strb", 32'(bk_wstrb), 32'h1);
        tick();
        chk("wfirst_single_start", 32'(bk_wstart), 32'd0);
        bk_wdone = 1'b1;
        tick();
        bk_wdone = 1'b0;
        chk("wfirst_bvalid", 32'(axi_bvalid), 32'd1);
        chk("wfirst_bresp", 32'(axi_bresp), 32'd0);
        axi_bready = 1'b1;
        tick();
        axi_bready = 1'b0;
        chk("wfirst_bvalid_drop", 32'(axi_bvalid), 32'd0);

        // Concurrent write and read with coincident backend completions
        axi_awaddr = 32'h10; axi_wdata = 32'h1111_0010; axi_wstrb = 4'hC;
        axi_araddr = 32'h20;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_arvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
        chk("conc_wstart", 32'(bk_wstart), 32'd1);
        chk("conc_rstart", 32'(bk_rstart), 32'd1);
        chk("conc_waddr", bk_waddr, 32'h10);
        chk("conc_raddr", bk_raddr, 32'h20);
        tick();
        bk_wdone = 1'b1; bk_rdone = 1'b1; bk_rdata = 32'hCAFE_0020;
        tick();
        bk_wdone = 1'b0; bk_rdone = 1'b0; bk_rdata = '0;
        chk("conc_bvalid", 32'(axi_bvalid), 32'd1);
        chk("conc_bresp", 32'(axi_bresp), 32'd0);
        chk("conc_rvalid", 32'(axi_rvalid), 32'd1);
        chk("conc_rresp", 32'(axi_rresp), 32'd0);
        chk("conc_rdata", axi_rdata, 32'hCAFE_0020);
        axi_bready = 1'b1; axi_rready = 1'b1;
        tick();
        axi_bready = 1'b0; axi_rready = 1'b0;
        chk("conc_bvalid_drop", 32'(axi_bvalid), 32'd0);
        chk("conc_rvalid_drop", 32'(axi_rvalid), 32'd0);

        // Reset while the write path waits on the backend
        axi_awaddr = 32'h0000_7000; axi_wdata = 32'h7777_7777; axi_wstrb = 4'hF;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        tick();
        tick();
        axi_aresetn = 1'b0;
        #1;
        chk("mid_rst_awready", 32'(axi_awready), 32'd0);
        chk("mid_rst_wready", 32'(axi_wready), 32'd0);
        chk("mid_rst_arready", 32'(axi_arready), 32'd0);
        chk("mid_rst_bvalid", 32'(axi_bvalid), 32'd0);
        chk("mid_rst_wstart", 32'(bk_wstart), 32'd0);
        chk("mid_rst_waddr", bk_waddr, 32'd0);
        chk("mid_rst_rdata", axi_rdata, 32'd0);
        tick();
        axi_aresetn = 1'b1;
        tick();
        chk("post_rst_awready", 32'(axi_awready), 32'd1);
        chk("post_rst_wready", 32'(axi_wready), 32'd1);
        chk("post_rst_arready", 32'(axi_arready), 32'd1);
        bk_wdone = 1'b1;
        tick();
        bk_wdone = 1'b0;
        repeat (3) begin
            tick();
            chk("post_rst_no_bvalid", 32'(axi_bvalid), 32'd0);
            chk("post_rst_no_wstart", 32'(bk_wstart), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
